// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel magnitude consumer and the output packer.
package sobel_pkg;

    typedef struct packed {
        logic sof;
        logic eol;
        logic mask;
    } raster_tag_t;

    // |gx|+|gy| of two (2W-1)-bit magnitudes always fits in 2W bits
    function automatic int mag_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/sobel_magnitude_elastic.sv
// Single-slot elastic register stage: accepts when empty or when draining this cycle.
module elastic_stage #(
    parameter int W_P = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [W_P-1:0] data_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [W_P-1:0] data_o
);

    assign ready_o = !valid_o || ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (ready_o) begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/sobel_magnitude_raster_counter.sv
// Raster position tracker; produces the sof/eol/border-mask tag for the sample being accepted.
module raster_counter
    import sobel_pkg::*;
#(
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clear_i,
    input  logic        advance_i,
    output raster_tag_t tag_o
);

    localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
    localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col <= '0;
            row <= '0;
        end else if (clear_i) begin
            col <= '0;
            row <= '0;
        end else if (advance_i) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Tag reflects the current (pre-advance, pre-clear) position
    always_comb begin
        tag_o      = '0;
        tag_o.sof  = (col == '0) && (row == '0);
        tag_o.eol  = (col == COL_LAST);
        tag_o.mask = ((col >> 1) == '0) || ((row >> 1) == '0);
    end

endmodule

// File: rtl/sobel_magnitude.sv
// Gradient-pair consumer: |gx|+|gy|, scale, saturate, threshold, border mask; two elastic stages.
module sobel_magnitude
    import sobel_pkg::*;
#(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16,
    parameter int SHIFT_P  = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*WIDTH_P-1:0]   gx_i,
    input  logic [2*WIDTH_P-1:0]   gy_i,
    input  logic [WIDTH_P-1:0]     thresh_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_P-1:0]     mag_o,
    output logic                   edge_o,
    output logic                   sof_o,
    output logic                   eol_o
);

    localparam int GW = 2 * WIDTH_P;
    localparam int AW = GW - 1;
    localparam int SW = mag_width(WIDTH_P);
    localparam logic [SW-1:0] MAG_MAX = SW'((1 << WIDTH_P) - 1);

    typedef struct packed {
        logic [SW-1:0] sum;
        raster_tag_t   tag;
    } s1_t;

    typedef struct packed {
        logic [WIDTH_P-1:0] mag;
        logic               edge_f;
        logic               sof;
        logic               eol;
    } s2_t;

    // Most negative input has no positive twin; clamp it to the largest magnitude
    function automatic logic [AW-1:0] abs_sat(input logic [GW-1:0] x);
        logic [GW-1:0] neg;
        neg = -x;
        if (!x[GW-1]) begin
            return x[AW-1:0];
        end else if (x[GW-2:0] == '0) begin
            return '1;
        end else begin
            return neg[AW-1:0];
        end
    endfunction

    raster_tag_t        tag_in;
    logic               in_fire;
    logic [AW-1:0]      abs_gx;
    logic [AW-1:0]      abs_gy;
    s1_t                s1_in;
    s1_t                s1_out;
    logic               s1_valid;
    logic               s2_ready;
    logic [SW-1:0]      scaled;
    logic [WIDTH_P-1:0] mag_sat;
    s2_t                s2_in;
    s2_t                s2_out;

    assign in_fire = valid_i && ready_o;

    raster_counter #(
        .DEPTH_P  (DEPTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_raster (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clear_i   (clear_i),
        .advance_i (in_fire),
        .tag_o     (tag_in)
    );

    always_comb begin
        abs_gx    = abs_sat(gx_i);
        abs_gy    = abs_sat(gy_i);
        s1_in     = '0;
        s1_in.sum = {1'b0, abs_gx} + {1'b0, abs_gy};
        s1_in.tag = tag_in;
    end

    elastic_stage #(
        .W_P ($bits(s1_t))
    ) u_stage1 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (s1_in),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_out)
    );

    // Border pixels are forced to zero so they can never raise an edge
    always_comb begin
        scaled       = s1_out.sum >> SHIFT_P;
        mag_sat      = (scaled > MAG_MAX) ? MAG_MAX[WIDTH_P-1:0] : scaled[WIDTH_P-1:0];
        s2_in        = '0;
        s2_in.mag    = s1_out.tag.mask ? '0 : mag_sat;
        s2_in.edge_f = !s1_out.tag.mask && (mag_sat >= thresh_i) && (mag_sat != '0);
        s2_in.sof    = s1_out.tag.sof;
        s2_in.eol    = s1_out.tag.eol;
    end

    elastic_stage #(
        .W_P ($bits(s2_t))
    ) u_stage2 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (s2_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (s2_out)
    );

    assign mag_o  = s2_out.mag;
    assign edge_o = s2_out.edge_f;
    assign sof_o  = s2_out.sof;
    assign eol_o  = s2_out.eol;

endmodule
